icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache. Answers the fetch stage's per-cycle instruction request
//  (inst_en/inst_addr -> inst_valid/inst). Hits return combinationally in the request cycle; misses
//  fetch one 32-bit word from the memory controller through a two-state fill FSM.
//  Sits between IF and the memory controller.
// PARAMETERS
//  INDEX_W   8   index bits; ICACHE_LINES = 2**INDEX_W lines, one 32-bit word each
//  TAG_W     22  tag bits = 32 - INDEX_W - 2
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  rdy           in   1   global enable; when low no state changes
//  inst_en_i     in   1   IF fetch request valid
//  inst_addr_i   in   32  IF fetch address, word aligned
//  inst_valid_o  out  1   inst_o holds the word at inst_addr_i this cycle
//  inst_o        out  32  instruction word
//  mem_en_o      out  1   fill request to memory controller, held until mem_valid_i
//  mem_addr_o    out  32  fill word address, {addr[31:2],2'b00}
//  mem_valid_i   in   1   one-cycle pulse: mem_inst_i valid for mem_addr_o
//  mem_inst_i    in   32  fill data
// BEHAVIOUR
//  - Reset: all valid bits 0, state IDLE, mem_en_o=0, mem_addr_o=0, miss_addr=0.
//    inst_valid_o=0 and inst_o=0 while rst is high.
//  - Address split: index = addr[INDEX_W+1:2], tag = addr[31:INDEX_W+2]. Bits [1:0] are ignored.
//  - hit = inst_en_i & valid[index] & (tag_arr[index]==tag).
//    Evaluated combinationally from registered arrays; legal in every state (hit-under-miss).
//  - inst_valid_o = hit | fwd, where fwd = (state==BUSY) & mem_valid_i & (miss_addr[31:2]==inst_addr_i[31:2]) & inst_en_i.
//    inst_o = fwd ? mem_inst_i : data_arr[index]. inst_o = 0 when inst_valid_o is 0.
//    The combinational hit path is mandatory: IF consumes the word in the same cycle and
//    advances inst_addr on the next edge.
//  - FSM states:
//      IDLE: if rdy & inst_en_i & ~hit -> mem_en_o<=1, mem_addr_o<={inst_addr_i[31:2],2'b00},
//            miss_addr<=same, go BUSY.
//      BUSY: mem_en_o stays 1 and mem_addr_o stays stable. On mem_valid_i:
//            valid/tag/data[miss index] <= 1/miss tag/mem_inst_i, mem_en_o<=0, go IDLE.
//  - Miss latency: request visible on the cycle after the miss; data forwarded on the mem_valid_i cycle.
//  - IF redirect while BUSY (inst_addr_i changes):
//      the fill is never aborted; it completes and is written for miss_addr.
//      fwd only fires if the current address matches miss_addr.
//      A new miss waits for IDLE.
//  - Fill completion and a new miss: the new miss is issued from IDLE on the following cycle at
//    the earliest (one bubble).
//  - Fill writes to the same index as a current hit: the hit reads the old content this cycle;
//    the new content is visible next cycle.
//  - mem_valid_i in IDLE is ignored; no array write.
//  - rdy=0: no array writes, no FSM transitions, registered outputs hold.
//    Combinational hit output is still driven (IF ignores it).
//  - rst mid-BUSY: mem_en_o drops on the next edge and the outstanding fill is discarded.
//    The memory controller must tolerate an abandoned request.
// STRUCTURE
//  - Shared defines file: `AddrBus, `InstBus, `Enable/`Disable, `Valid/`Invalid, `Null,
//    ICACHE_INDEX_W, state encodings `IC_IDLE/`IC_BUSY.
//  - One natural sub-module: icache_array. It holds valid/tag/data registers with one
//    combinational read port and one synchronous write port; valid is cleared on rst.
//  - FSM and hit/forward logic stay in icache.
// TESTING
//  1 Cold miss: rst, then inst_en=1, addr=0x0000_0000. Expect inst_valid_o=0, and mem_en_o=1 with
//    mem_addr_o=0 on the next cycle. After mem_valid_i with 0x0000_0513, expect inst_valid_o=1 and
//    inst_o=0x0000_0513 in the same cycle.
//  2 Hit after fill: re-present 0x0. Expect inst_valid_o=1 combinationally, mem_en_o stays 0.
//  3 Conflict: fill 0x0000_0000, then request 0x0000_0400 (same index 0, different tag). Expect a miss
//    and a fill; a subsequent request to 0x0 misses again.
//  4 Redirect mid-miss: miss on 0x100, then switch addr to 0x200 while BUSY. Expect inst_valid_o=0 on the
//    mem_valid_i cycle and line 0x100 filled. Expect a new request for 0x200 one cycle later.
//  5 Hit-under-miss: 0x8 cached. While BUSY on 0x1000, request 0x8. Expect inst_valid_o=1 immediately
//    and mem_addr_o still 0x1000.
//  6 rdy=0 while BUSY with mem_valid_i pulsing: expect no array write and state unchanged.
//    rst while BUSY: expect mem_en_o=0 next cycle and a miss on 0x0.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared constants, bus types and helpers for the direct-mapped
//                instruction cache (address/instruction bus widths, default
//                index width, fill FSM state encodings).
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int unsigned c_addr_w         = 32;
    localparam int unsigned c_inst_w         = 32;
    localparam int unsigned c_icache_index_w = 8;

    // Fill FSM state encodings
    localparam logic [0:0] c_ic_idle = 1'b0;
    localparam logic [0:0] c_ic_busy = 1'b1;

    typedef logic [c_addr_w-1:0] addr_bus_t;
    typedef logic [c_inst_w-1:0] inst_bus_t;

    // Word-aligned form of a byte address (byte offset forced to zero)
    function automatic addr_bus_t word_addr(input addr_bus_t a);
        return {a[c_addr_w-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_array
//  Description : Valid/tag/data storage for the direct-mapped instruction
//                cache. One combinational read port, one synchronous write
//                port. Only the valid bits are cleared by reset.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_rd_index          - read line index
//                o_rd_valid/tag/data - contents of the addressed line
//                i_wr_en             - write strobe
//                i_wr_index/tag/data - line written on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_W = c_icache_index_w,
    parameter int unsigned TAG_W   = c_addr_w - INDEX_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output inst_bus_t          o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  inst_bus_t          i_wr_data
);

    localparam int unsigned c_lines = 2 ** INDEX_W;

    logic [c_lines-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [c_lines];
    inst_bus_t          r_data [c_lines];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by the valid bit
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped read-only instruction cache between IF and the
//                memory controller. Hits (and fill data matching the current
//                request) are returned combinationally in the request cycle;
//                misses fetch one word through a two-state fill FSM.
//  Ports       : clk, rst, rdy              - clock, sync reset, global enable
//                inst_en_i, inst_addr_i     - IF fetch request
//                inst_valid_o, inst_o       - fetch response (same cycle)
//                mem_en_o, mem_addr_o       - fill request to memory
//                mem_valid_i, mem_inst_i    - fill response pulse and data
//  Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_W = c_icache_index_w,
    parameter int unsigned TAG_W   = c_addr_w - INDEX_W - 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      inst_en_i,
    input  addr_bus_t inst_addr_i,
    output logic      inst_valid_o,
    output inst_bus_t inst_o,
    output logic      mem_en_o,
    output addr_bus_t mem_addr_o,
    input  logic      mem_valid_i,
    input  inst_bus_t mem_inst_i
);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    addr_bus_t          r_miss_addr;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_line_valid;
    logic [TAG_W-1:0]   w_line_tag;
    inst_bus_t          w_line_data;
    logic               w_hit;
    logic               w_fwd;
    logic               w_miss;
    logic               w_fill;
    logic               w_wr_en;
    logic [1:0]         w_unused_addr_lsb;

    assign w_index           = inst_addr_i[INDEX_W+1:2];
    assign w_tag             = inst_addr_i[c_addr_w-1:INDEX_W+2];
    assign w_unused_addr_lsb = inst_addr_i[1:0];

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_index),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (r_miss_addr[INDEX_W+1:2]),
        .i_wr_tag   (r_miss_addr[c_addr_w-1:INDEX_W+2]),
        .i_wr_data  (mem_inst_i)
    );

    // Hit is legal in any state, so hits keep flowing while a fill is pending
    assign w_hit  = inst_en_i & w_line_valid & (w_line_tag == w_tag);
    // Fill data goes straight to IF only if IF still asks for the missed word
    assign w_fwd  = (r_state == c_ic_busy) & mem_valid_i & inst_en_i
                  & (r_miss_addr[c_addr_w-1:2] == inst_addr_i[c_addr_w-1:2]);
    assign w_miss = rdy & (r_state == c_ic_idle) & inst_en_i & ~w_hit;
    assign w_fill = rdy & (r_state == c_ic_busy) & mem_valid_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ic_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Miss address is captured only when a fill is launched, so it stays
    // stable for the whole BUSY period regardless of IF redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss_addr <= '0;
        end else if (w_miss) begin
            r_miss_addr <= word_addr(inst_addr_i);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ic_idle: if (w_miss) w_state_nxt = c_ic_busy;
            c_ic_busy: if (w_fill) w_state_nxt = c_ic_idle;
            default:   w_state_nxt = c_ic_idle;
        endcase
    end

    // Output logic
    always_comb begin
        mem_en_o     = (r_state == c_ic_busy);
        mem_addr_o   = r_miss_addr;
        // A fill coinciding with reset is dropped
        w_wr_en      = w_fill & ~rst;
        inst_valid_o = ~rst & (w_hit | w_fwd);
        inst_o       = '0;
        if (inst_valid_o) begin
            inst_o = w_fwd ? mem_inst_i : w_line_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Self-checking bench for icache: directed scenarios with
//                hand-derived expectations, then a randomized run against a
//                behavioural cache model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        inst_en_i;
    logic [31:0] inst_addr_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i;
    logic [31:0] mem_inst_i;

    int checks = 0;
    int passed = 0;

    icache dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .inst_en_i    (inst_en_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .mem_en_o     (mem_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_valid_i  (mem_valid_i),
        .mem_inst_i   (mem_inst_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change mid-cycle; outputs are observed 1ns later, well before
    // the next rising edge commits the cycle.
    task automatic drive(input logic r, input logic rd, input logic en,
                         input logic [31:0] a, input logic mv, input logic [31:0] md);
        @(negedge clk);
        rst         = r;
        rdy         = rd;
        inst_en_i   = en;
        inst_addr_i = a;
        mem_valid_i = mv;
        mem_inst_i  = md;
        #1;
    endtask

    task automatic step(input logic [31:0] a, input logic mv, input logic [31:0] md);
        drive(1'b0, 1'b1, 1'b1, a, mv, md);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %b exp 0", inst_valid_o); else passed++;
        checks++; if (inst_o !== 32'h0) $display("FAIL reset_inst: got %h exp 0", inst_o); else passed++;
        drive(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b0) $display("FAIL reset_mem_en: got %b exp 0", mem_en_o); else passed++;
        checks++; if (mem_addr_o !== 32'h0) $display("FAIL reset_mem_addr: got %h exp 0", mem_addr_o); else passed++;
    endtask

    task automatic test_cold_miss();
        step(32'h0, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL cold_valid: got %b exp 0", inst_valid_o); else passed++;
        checks++; if (mem_en_o !== 1'b0) $display("FAIL cold_mem_en_early: got %b exp 0", mem_en_o); else passed++;
        step(32'h0, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b1) $display("FAIL cold_mem_en: got %b exp 1", mem_en_o); else passed++;
        checks++; if (mem_addr_o !== 32'h0) $display("FAIL cold_mem_addr: got %h exp 0", mem_addr_o); else passed++;
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL cold_busy_valid: got %b exp 0", inst_valid_o); else passed++;
        step(32'h0, 1'b1, 32'h0000_0513);
        checks++; if (inst_valid_o !== 1'b1) $display("FAIL cold_fwd_valid: got %b exp 1", inst_valid_o); else passed++;
        checks++; if (inst_o !== 32'h0000_0513) $display("FAIL cold_fwd_inst: got %h exp 00000513", inst_o); else passed++;
    endtask

    task automatic test_hit();
        step(32'h0, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b1) $display("FAIL hit_valid: got %b exp 1", inst_valid_o); else passed++;
        checks++; if (inst_o !== 32'h0000_0513) $display("FAIL hit_inst: got %h exp 00000513", inst_o); else passed++;
        checks++; if (mem_en_o !== 1'b0) $display("FAIL hit_mem_en: got %b exp 0", mem_en_o); else passed++;
        step(32'h0, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b0) $display("FAIL hit_no_fill: got %b exp 0", mem_en_o); else passed++;
    endtask

    task automatic test_conflict();
        step(32'h400, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL conf_miss: got %b exp 0", inst_valid_o); else passed++;
        step(32'h400, 1'b0, 32'h0);
        checks++; if (mem_addr_o !== 32'h400 || mem_en_o !== 1'b1) $display("FAIL conf_req: got en=%b addr=%h exp en=1 addr=00000400", mem_en_o, mem_addr_o); else passed++;
        step(32'h400, 1'b1, 32'hAAAA_0400);
        checks++; if (inst_o !== 32'hAAAA_0400) $display("FAIL conf_fwd: got %h exp aaaa0400", inst_o); else passed++;
        step(32'h0, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL conf_evicted: got %b exp 0", inst_valid_o); else passed++;
        step(32'h0, 1'b0, 32'h0);
        checks++; if (mem_addr_o !== 32'h0 || mem_en_o !== 1'b1) $display("FAIL conf_refill_req: got en=%b addr=%h exp en=1 addr=0", mem_en_o, mem_addr_o); else passed++;
        step(32'h0, 1'b1, 32'h0000_0513);
        checks++; if (inst_valid_o !== 1'b1) $display("FAIL conf_refill: got %b exp 1", inst_valid_o); else passed++;
    endtask

    task automatic test_redirect();
        step(32'h100, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL redir_miss: got %b exp 0", inst_valid_o); else passed++;
        step(32'h200, 1'b0, 32'h0);
        checks++; if (mem_addr_o !== 32'h100) $display("FAIL redir_addr_stable: got %h exp 00000100", mem_addr_o); else passed++;
        step(32'h200, 1'b1, 32'h0000_1111);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL redir_no_fwd: got %b exp 0", inst_valid_o); else passed++;
        checks++; if (inst_o !== 32'h0) $display("FAIL redir_inst_zero: got %h exp 0", inst_o); else passed++;
        step(32'h200, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b0) $display("FAIL redir_bubble: got %b exp 0", mem_en_o); else passed++;
        step(32'h200, 1'b0, 32'h0);
        checks++; if (mem_addr_o !== 32'h200 || mem_en_o !== 1'b1) $display("FAIL redir_new_req: got en=%b addr=%h exp en=1 addr=00000200", mem_en_o, mem_addr_o); else passed++;
        step(32'h200, 1'b1, 32'h0000_2222);
        checks++; if (inst_o !== 32'h0000_2222) $display("FAIL redir_fill2: got %h exp 00002222", inst_o); else passed++;
        step(32'h100, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_1111) $display("FAIL redir_line_filled: got v=%b inst=%h exp v=1 inst=00001111", inst_valid_o, inst_o); else passed++;
    endtask

    task automatic test_hit_under_miss();
        step(32'h8, 1'b0, 32'h0);
        step(32'h8, 1'b0, 32'h0);
        step(32'h8, 1'b1, 32'h0000_8888);
        step(32'h1000, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL hum_miss: got %b exp 0", inst_valid_o); else passed++;
        step(32'h8, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_8888) $display("FAIL hum_hit: got v=%b inst=%h exp v=1 inst=00008888", inst_valid_o, inst_o); else passed++;
        checks++; if (mem_addr_o !== 32'h1000 || mem_en_o !== 1'b1) $display("FAIL hum_req_held: got en=%b addr=%h exp en=1 addr=00001000", mem_en_o, mem_addr_o); else passed++;
        step(32'h1000, 1'b1, 32'h1000_1000);
        checks++; if (inst_o !== 32'h1000_1000) $display("FAIL hum_fill: got %h exp 10001000", inst_o); else passed++;
    endtask

    task automatic test_rdy_stall();
        step(32'h2000, 1'b0, 32'h0);
        step(32'h2000, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b1) $display("FAIL stall_busy: got %b exp 1", mem_en_o); else passed++;
        drive(1'b0, 1'b0, 1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF);
        step(32'h2000, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h2000) $display("FAIL stall_state_held: got en=%b addr=%h exp en=1 addr=00002000", mem_en_o, mem_addr_o); else passed++;
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL stall_no_write: got %b exp 0", inst_valid_o); else passed++;
        step(32'h2000, 1'b1, 32'h0000_2020);
        step(32'h2000, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_2020) $display("FAIL stall_after_fill: got v=%b inst=%h exp v=1 inst=00002020", inst_valid_o, inst_o); else passed++;
    endtask

    task automatic test_rst_busy();
        step(32'h3000, 1'b0, 32'h0);
        step(32'h3000, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b1) $display("FAIL rstb_busy: got %b exp 1", mem_en_o); else passed++;
        drive(1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL rstb_valid_in_rst: got %b exp 0", inst_valid_o); else passed++;
        // Late response to the abandoned request arrives in IDLE
        step(32'h0, 1'b1, 32'h0000_0BAD);
        checks++; if (mem_en_o !== 1'b0) $display("FAIL rstb_mem_en_drop: got %b exp 0", mem_en_o); else passed++;
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL rstb_cleared: got %b exp 0", inst_valid_o); else passed++;
        step(32'h0, 1'b0, 32'h0);
        checks++; if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h0) $display("FAIL rstb_miss0: got en=%b addr=%h exp en=1 addr=0", mem_en_o, mem_addr_o); else passed++;
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL rstb_idle_ignored: got %b exp 0", inst_valid_o); else passed++;
        step(32'h0, 1'b1, 32'h0000_0513);
        step(32'h3000, 1'b0, 32'h0);
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL rstb_fill_discarded: got %b exp 0", inst_valid_o); else passed++;
    endtask

    task automatic test_random();
        bit          m_valid [256];
        logic [21:0] m_tag   [256];
        logic [31:0] m_data  [256];
        bit          m_busy;
        logic [31:0] m_miss;
        logic [21:0] tpool   [4];
        logic        r, rd, en, mv, e_hit, e_fwd, e_valid;
        logic [31:0] a, md, e_inst;
        logic [7:0]  idx;
        logic [21:0] tg;

        tpool[0] = 22'h0; tpool[1] = 22'h1; tpool[2] = 22'h2A; tpool[3] = 22'h3FFFFF;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0;
        m_miss = 32'h0;

        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            rd = ($urandom_range(0, 9) != 0);
            en = ($urandom_range(0, 99) < 85);
            a  = {tpool[$urandom_range(0, 3)], 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            mv = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            md = $urandom;
            drive(r, rd, en, a, mv, md);

            idx     = a[9:2];
            tg      = a[31:10];
            e_hit   = en && m_valid[idx] && (m_tag[idx] == tg);
            e_fwd   = m_busy && mv && en && (m_miss[31:2] == a[31:2]);
            e_valid = !r && (e_hit || e_fwd);
            e_inst  = !e_valid ? 32'h0 : (e_fwd ? md : m_data[idx]);

            checks++; if (inst_valid_o !== e_valid) $display("FAIL rnd_valid cyc %0d: got %b exp %b", n, inst_valid_o, e_valid); else passed++;
            checks++; if (inst_o !== e_inst) $display("FAIL rnd_inst cyc %0d: got %h exp %h", n, inst_o, e_inst); else passed++;
            checks++; if (mem_en_o !== m_busy) $display("FAIL rnd_mem_en cyc %0d: got %b exp %b", n, mem_en_o, m_busy); else passed++;
            checks++; if (mem_addr_o !== m_miss) $display("FAIL rnd_mem_addr cyc %0d: got %h exp %h", n, mem_addr_o, m_miss); else passed++;

            if (r) begin
                for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
                m_busy = 1'b0;
                m_miss = 32'h0;
            end else if (rd) begin
                if (m_busy && mv) begin
                    m_valid[m_miss[9:2]] = 1'b1;
                    m_tag[m_miss[9:2]]   = m_miss[31:10];
                    m_data[m_miss[9:2]]  = md;
                    m_busy = 1'b0;
                end else if (!m_busy && en && !e_hit) begin
                    m_busy = 1'b1;
                    m_miss = {a[31:2], 2'b00};
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; inst_en_i = 1'b0; inst_addr_i = 32'h0;
        mem_valid_i = 1'b0; mem_inst_i = 32'h0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_redirect();
        test_hit_under_miss();
        test_rdy_stall();
        test_rst_busy();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
